// File: rtl/la_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | la_pkg                                                                     |
// | Shared types and default constants for the logic analyzer serial path.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package la_pkg;

    localparam int LA_BYTE_W       = 8;
    localparam int LA_CLKS_PER_BIT = 434;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_START = 3'd3,
        ST_DATA  = 3'd4,
        ST_STOP  = 3'd5
    } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/byte_uart_tx_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | byte_uart_tx_if                                                            |
// | get / byte_ready handshake between the byte queue and the serial stage.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface byte_uart_tx_if
    import la_pkg::*;
#(
    parameter int N = LA_BYTE_W
);
    logic         get;
    logic         data_avail;
    logic         byte_ready;
    logic [N-1:0] byte_in;

    // master: the requester pulling bytes; slave: the byte queue answering
    modport master (output get, input data_avail, input byte_ready, input byte_in);
    modport slave  (input get, output data_avail, output byte_ready, output byte_in);
endinterface
`default_nettype wire

// File: rtl/byte_uart_tx_baud_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | baud_counter                                                               |
// | Loadable down-counter; tick_o is high while the count sits at zero.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module baud_counter #(
    parameter int W = 9
) (
    input  wire logic         rdclk,
    input  wire logic         nreset,
    input  wire logic         load_i,
    input  wire logic [W-1:0] load_val_i,
    output logic      [W-1:0] count_o,
    output logic              tick_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge rdclk) begin
        if (!nreset) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign count_o = cnt_q;
    assign tick_o  = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/byte_uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | byte_uart_tx                                                               |
// | Pulls bytes from the byte queue and sends them as 8N1/8N2 serial, LSB first.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module byte_uart_tx
    import la_pkg::*;
#(
    parameter int N            = LA_BYTE_W,
    parameter int CLKS_PER_BIT = LA_CLKS_PER_BIT,
    parameter int STOP_BITS    = 1,
    parameter int RESP_TIMEOUT = 8
) (
    input  wire logic       rdclk,
    input  wire logic       nreset,
    input  wire logic       en,
    byte_uart_tx_if.master  up,
    output logic            tx,
    output logic            busy,
    output logic            tx_done,
    output logic            err_timeout
);

    localparam int CNT_W = (STOP_BITS * CLKS_PER_BIT > 1) ? $clog2(STOP_BITS * CLKS_PER_BIT) : 1;
    localparam int IDX_W = $clog2(N + 1);
    localparam int WT_W  = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;

    localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] STOP_LOAD = CNT_W'(STOP_BITS * CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N - 1);
    localparam logic [WT_W-1:0]  WT_LAST   = WT_W'(RESP_TIMEOUT - 1);

    tx_state_t        state_q, state_d;
    logic [N-1:0]     shreg_q, shreg_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WT_W-1:0]  wcnt_q, wcnt_d;
    logic             err_q, err_d;
    logic             tx_q, tx_d;
    logic             get_q, get_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic [CNT_W-1:0] cnt;
    logic             cnt_tick;

    baud_counter #(
        .W (CNT_W)
    ) u_baud (
        .rdclk      (rdclk),
        .nreset     (nreset),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .count_o    (cnt),
        .tick_o     (cnt_tick)
    );

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        idx_d        = idx_q;
        wcnt_d       = wcnt_q;
        err_d        = err_q;
        cnt_load     = 1'b0;
        cnt_load_val = BIT_LOAD;

        case (state_q)
            ST_IDLE: begin
                if (en && up.data_avail) state_d = ST_REQ;
            end
            ST_REQ: begin
                state_d = ST_WAIT;
                wcnt_d  = '0;
            end
            ST_WAIT: begin
                // byte_ready is only honoured here; stray pulses elsewhere are dropped
                if (up.byte_ready) begin
                    shreg_d  = up.byte_in;
                    state_d  = ST_START;
                    cnt_load = 1'b1;
                end else if (wcnt_q == WT_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            ST_START: begin
                if (cnt_tick) begin
                    state_d  = ST_DATA;
                    idx_d    = '0;
                    cnt_load = 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt_tick) begin
                    shreg_d  = {1'b0, shreg_q[N-1:1]};
                    idx_d    = idx_q + 1'b1;
                    cnt_load = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d      = ST_STOP;
                        cnt_load_val = STOP_LOAD;
                    end
                end
            end
            ST_STOP: begin
                if (cnt_tick) state_d = (en && up.data_avail) ? ST_REQ : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from next state so the flops line up with state_q
    always_comb begin
        tx_d   = (state_d == ST_START) ? 1'b0 :
                 (state_d == ST_DATA)  ? shreg_d[0] : 1'b1;
        get_d  = (state_d == ST_REQ);
        busy_d = (state_d != ST_IDLE);
        done_d = (state_q == ST_STOP) && (cnt == CNT_W'(1));
    end

    always_ff @(posedge rdclk) begin
        if (!nreset) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            idx_q   <= '0;
            wcnt_q  <= '0;
            err_q   <= 1'b0;
            tx_q    <= 1'b1;
            get_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
            wcnt_q  <= wcnt_d;
            err_q   <= err_d;
            tx_q    <= tx_d;
            get_q   <= get_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign up.get      = get_q;
    assign tx          = tx_q;
    assign busy        = busy_q;
    assign tx_done     = done_q;
    assign err_timeout = err_q;

endmodule
`default_nettype wire

// File: tb/tb_byte_uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_byte_uart_tx                                                            |
// | Directed checks of byte_uart_tx at 4 clocks/bit, 1 and 2 stop bits.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_byte_uart_tx;

    localparam int CPB = 4;

    logic rdclk  = 1'b0;
    logic nreset = 1'b0;
    logic en1, en2;
    logic tx1, busy1, done1, err1;
    logic tx2, busy2, done2, err2;

    int checks = 0;
    int errors = 0;

    always #5 rdclk = ~rdclk;

    byte_uart_tx_if #(.N(8)) u1 ();
    byte_uart_tx_if #(.N(8)) u2 ();

    byte_uart_tx #(.N(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .RESP_TIMEOUT(8)) dut1 (
        .rdclk(rdclk), .nreset(nreset), .en(en1), .up(u1),
        .tx(tx1), .busy(busy1), .tx_done(done1), .err_timeout(err1)
    );

    byte_uart_tx #(.N(8), .CLKS_PER_BIT(CPB), .STOP_BITS(2), .RESP_TIMEOUT(8)) dut2 (
        .rdclk(rdclk), .nreset(nreset), .en(en2), .up(u2),
        .tx(tx2), .busy(busy2), .tx_done(done2), .err_timeout(err2)
    );

    // {tx, busy, tx_done, get, err_timeout}
    function automatic logic [4:0] outs(input bit sel);
        return sel ? {tx2, busy2, done2, u2.get, err2} : {tx1, busy1, done1, u1.get, err1};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge rdclk);
        #1;
    endtask

    task automatic set_br(input bit sel, input logic br, input logic [7:0] bi);
        if (sel) begin
            u2.byte_ready = br;
            u2.byte_in    = bi;
        end else begin
            u1.byte_ready = br;
            u1.byte_in    = bi;
        end
    endtask

    // Entered in the REQ cycle; returns in the first START cycle
    task automatic handshake(input bit sel, input logic [7:0] b, input string tag);
        logic [4:0] o;
        o = outs(sel);
        chk({tag, "/req_get"}, o[1], 1);
        chk({tag, "/req_busy"}, o[3], 1);
        step();
        o = outs(sel);
        chk({tag, "/wait_get"}, o[1], 0);
        chk({tag, "/wait_tx"}, o[4], 1);
        set_br(sel, 1'b1, b);
        step();
        set_br(sel, 1'b0, 8'h00);
    endtask

    // Walks a whole frame from the first START cycle; stray >= 0 injects a byte_ready there
    task automatic check_frame(input bit sel, input logic [7:0] b, input int sb,
                               input int stray, input string tag);
        int nbits;
        int bit_n;
        logic exp_bit;
        logic [4:0] o;
        nbits = 9 + sb;
        for (int i = 0; i < nbits * CPB; i++) begin
            bit_n = i / CPB;
            if (bit_n == 0)      exp_bit = 1'b0;
            else if (bit_n <= 8) exp_bit = b[bit_n-1];
            else                 exp_bit = 1'b1;
            o = outs(sel);
            chk({tag, "/tx"}, o[4], exp_bit);
            chk({tag, "/busy"}, o[3], 1);
            chk({tag, "/done"}, o[2], (i == nbits * CPB - 1));
            chk({tag, "/get"}, o[1], 0);
            if (i == stray)          set_br(sel, 1'b1, ~b);
            else if (i == stray + 1) set_br(sel, 1'b0, 8'h00);
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] o;
        logic [0:9] a5_seq;
        a5_seq = 10'b0101001011;

        en1 = 1'b0; en2 = 1'b0;
        u1.data_avail = 1'b0; u1.byte_ready = 1'b0; u1.byte_in = 8'h00;
        u2.data_avail = 1'b0; u2.byte_ready = 1'b0; u2.byte_in = 8'h00;
        nreset = 1'b0;
        repeat (3) step();

        // reset state
        o = outs(0);
        chk("rst/tx", o[4], 1);
        chk("rst/busy", o[3], 0);
        chk("rst/done", o[2], 0);
        chk("rst/get", o[1], 0);
        chk("rst/err", o[0], 0);
        o = outs(1);
        chk("rst2/tx", o[4], 1);
        chk("rst2/busy", o[3], 0);
        nreset = 1'b1;
        step();

        // single byte 0xA5, hand-written line sequence
        en1 = 1'b1; u1.data_avail = 1'b1;
        step();
        u1.data_avail = 1'b0;
        handshake(0, 8'hA5, "t1");
        for (int i = 0; i < 10 * CPB; i++) begin
            o = outs(0);
            chk("t1/tx", o[4], a5_seq[i/CPB]);
            chk("t1/done", o[2], (i == 10 * CPB - 1));
            chk("t1/get", o[1], 0);
            step();
        end
        o = outs(0);
        chk("t1/idle_busy", o[3], 0);
        chk("t1/idle_tx", o[4], 1);
        chk("t1/idle_get", o[1], 0);
        step();
        o = outs(0);
        chk("t1/idle_get2", o[1], 0);

        // back-to-back frames; stray byte_ready mid-DATA in the second one
        u1.data_avail = 1'b1;
        step();
        handshake(0, 8'h00, "t2a");
        check_frame(0, 8'h00, 1, -1, "t2a");
        handshake(0, 8'hFF, "t2b");
        check_frame(0, 8'hFF, 1, 10, "t2b");
        handshake(0, 8'h3C, "t2c");
        u1.data_avail = 1'b0;
        check_frame(0, 8'h3C, 1, -1, "t2c");
        o = outs(0);
        chk("t2/idle_busy", o[3], 0);
        chk("t2/idle_get", o[1], 0);

        // response timeout
        u1.data_avail = 1'b1;
        step();
        o = outs(0);
        chk("t3/get", o[1], 1);
        u1.data_avail = 1'b0;
        for (int k = 2; k <= 9; k++) begin
            step();
            o = outs(0);
            chk("t3/err_early", o[0], 0);
            chk("t3/tx", o[4], 1);
            chk("t3/busy", o[3], 1);
        end
        step();
        o = outs(0);
        chk("t3/err_set", o[0], 1);
        chk("t3/busy_idle", o[3], 0);
        chk("t3/tx_idle", o[4], 1);
        u1.data_avail = 1'b1;
        step();
        handshake(0, 8'h5A, "t3b");
        u1.data_avail = 1'b0;
        check_frame(0, 8'h5A, 1, -1, "t3b");
        o = outs(0);
        chk("t3/err_sticky", o[0], 1);

        // reset during DATA bit 3
        u1.data_avail = 1'b1;
        step();
        handshake(0, 8'hC3, "t4");
        u1.data_avail = 1'b0;
        repeat (16) step();
        o = outs(0);
        chk("t4/bit3", o[4], 0);
        nreset = 1'b0;
        step();
        o = outs(0);
        chk("t4/rst_tx", o[4], 1);
        chk("t4/rst_busy", o[3], 0);
        chk("t4/rst_get", o[1], 0);
        chk("t4/rst_done", o[2], 0);
        chk("t4/rst_err", o[0], 0);
        nreset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            o = outs(0);
            chk("t4/no_get", o[1], 0);
            chk("t4/no_busy", o[3], 0);
        end

        // en dropped mid-frame with data still available
        u1.data_avail = 1'b1;
        step();
        handshake(0, 8'h96, "t5");
        en1 = 1'b0;
        check_frame(0, 8'h96, 1, -1, "t5");
        for (int k = 0; k < 4; k++) begin
            o = outs(0);
            chk("t5/hold_get", o[1], 0);
            chk("t5/hold_busy", o[3], 0);
            step();
        end
        en1 = 1'b1;
        step();
        en1 = 1'b0;
        handshake(0, 8'h01, "t5b");
        u1.data_avail = 1'b0;
        check_frame(0, 8'h01, 1, -1, "t5b");
        o = outs(0);
        chk("t5b/idle_busy", o[3], 0);
        en1 = 1'b1;

        // two stop bits with a stray byte_ready inside STOP
        en2 = 1'b1; u2.data_avail = 1'b1;
        step();
        u2.data_avail = 1'b0;
        handshake(1, 8'h6B, "t6");
        check_frame(1, 8'h6B, 2, 9 * CPB + 2, "t6");
        o = outs(1);
        chk("t6/idle_busy", o[3], 0);
        chk("t6/idle_tx", o[4], 1);
        chk("t6/idle_get", o[1], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
